mp_add_seq: RTL and testbench

//  Multi-precision add sequencer: computes a WIDE = SLICE_W*NSLICES bit sum by

---
 rtl/mp_add_seq_pkg.sv | 19 +
 rtl/mp_add_seq_if.sv | 33 +++
 rtl/mp_add_seq_add_slice.sv | 28 ++
 rtl/mp_add_seq.sv | 97 +++++++++
 tb/tb_mp_add_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the multi-precision add sequencer: state
// encodings, default geometry and a small width helper.
package mp_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_SLICE_W = 4;
    localparam int DEF_NSLICES = 4;

    // Slice counter width; a single-slice build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Operand/result handshake bundle between producer, sequencer and consumer.
interface mp_add_seq_if
    import mp_add_pkg::*;
#(
    parameter int SLICE_W = DEF_SLICE_W,
    parameter int NSLICES = DEF_NSLICES
);
    localparam int WIDE = SLICE_W * NSLICES;

    logic            in_valid;
    logic            in_ready;
    logic [WIDE-1:0] a;
    logic [WIDE-1:0] b;
    logic            cin;
    logic            out_valid;
    logic            out_ready;
    logic [WIDE-1:0] sum;
    logic            cout;
    logic            busy;

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/mp_add_seq_add_slice.sv
// Purely combinational SLICE_W-bit ripple-carry adder, shared across all
// slices of the wide operands.
module add_slice
    import mp_add_pkg::*;
#(
    parameter int SLICE_W = DEF_SLICE_W
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic c;

    // Ripple the carry bit by bit, least-significant bit first.
    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: one shared slice adder is stepped across
// the operands LSB slice first, carrying through a register, trading
// latency for adder area.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int SLICE_W = DEF_SLICE_W,
    parameter int NSLICES = DEF_NSLICES
) (
    input logic         clk,
    input logic         rst,
    mp_add_seq_if.slave bus
);

    localparam int WIDE  = SLICE_W * NSLICES;
    localparam int IDX_W = idx_width(NSLICES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICES - 1);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               cout_r;
    logic [WIDE-1:0]    a_r;
    logic [WIDE-1:0]    b_r;
    logic [WIDE-1:0]    sum_r;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_c;

    assign sl_a = a_r[idx*SLICE_W +: SLICE_W];
    assign sl_b = b_r[idx*SLICE_W +: SLICE_W];

    add_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .sum  (sl_s),
        .cout (sl_c)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic: accept in IDLE, step slices in RUN, wait for consumer in DONE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  next_state = ST_RUN;
            ST_RUN:  if (idx == LAST)   next_state = ST_DONE;
            ST_DONE: if (bus.out_ready) next_state = ST_IDLE;
            default:                    next_state = ST_IDLE;
        endcase
    end

    // Datapath: capture operands on acceptance, then write one sum slice per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        carry <= bus.cin;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_r[idx*SLICE_W +: SLICE_W] <= sl_s;
                    carry <= sl_c;
                    if (idx == LAST) cout_r <= sl_c;
                    else             idx    <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq: a 4x4-bit build and a single-slice build.
module tb_mp_add_seq;
    import mp_add_pkg::*;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    exp_t q4[$];
    exp_t q1[$];

    mp_add_seq_if #(.SLICE_W(4), .NSLICES(4)) bus4 ();
    mp_add_seq_if #(.SLICE_W(4), .NSLICES(1)) bus1 ();

    mp_add_seq #(.SLICE_W(4), .NSLICES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    mp_add_seq #(.SLICE_W(4), .NSLICES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic outValid(input bit sel);
        return sel ? bus1.out_valid : bus4.out_valid;
    endfunction

    function automatic logic inReady(input bit sel);
        return sel ? bus1.in_ready : bus4.in_ready;
    endfunction

    function automatic logic [15:0] outSum(input bit sel);
        return sel ? {12'h000, bus1.sum} : bus4.sum;
    endfunction

    function automatic logic outCout(input bit sel);
        return sel ? bus1.cout : bus4.cout;
    endfunction

    task automatic setInputs(input bit sel, input logic v, input logic [15:0] a,
                             input logic [15:0] b, input logic cin);
        if (sel) begin
            bus1.in_valid = v; bus1.a = a[3:0]; bus1.b = b[3:0]; bus1.cin = cin;
        end else begin
            bus4.in_valid = v; bus4.a = a; bus4.b = b; bus4.cin = cin;
        end
    endtask

    task automatic setOutReady(input bit sel, input logic r);
        if (sel) bus1.out_ready = r;
        else     bus4.out_ready = r;
    endtask

    // Issue one add, push its hand-computed result, check latency and
    // optionally hold the result under backpressure for 'hold' cycles.
    task automatic applyStimulus(input bit sel, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic [15:0] expSum,
                                 input logic expCout, input int hold);
        exp_t e;
        int   lat;
        int   nsl;
        nsl = sel ? 1 : 4;
        e.sum  = expSum;
        e.cout = expCout;
        if (sel) q1.push_back(e);
        else     q4.push_back(e);
        checkOutput("ready_before_issue", {31'd0, inReady(sel)}, 32'd1);
        setInputs(sel, 1'b1, a, b, cin);
        @(posedge clk); #1;
        setInputs(sel, 1'b0, 16'h0, 16'h0, 1'b0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (outValid(sel)) break;
        end
        checkOutput("latency", lat, nsl);
        for (int i = 0; i < hold; i++) begin
            setInputs(sel, (i == 1), 16'hAAAA, 16'h5555, 1'b1);
            @(posedge clk); #1;
            checkOutput("hold_out_valid", {31'd0, outValid(sel)}, 32'd1);
            checkOutput("hold_in_ready", {31'd0, inReady(sel)}, 32'd0);
            checkOutput("hold_sum", {16'd0, outSum(sel)}, {16'd0, expSum});
            checkOutput("hold_cout", {31'd0, outCout(sel)}, {31'd0, expCout});
        end
        setInputs(sel, 1'b0, 16'h0, 16'h0, 1'b0);
        setOutReady(sel, 1'b1);
        @(posedge clk); #1;
        setOutReady(sel, 1'b0);
        checkOutput("idle_out_valid", {31'd0, outValid(sel)}, 32'd0);
        checkOutput("idle_in_ready", {31'd0, inReady(sel)}, 32'd1);
        checkOutput("idle_sum_kept", {16'd0, outSum(sel)}, {16'd0, expSum});
    endtask

    // Monitor for the 4-slice build: compare every accepted result against the queue.
    always @(negedge clk) begin
        if (!rst && bus4.out_valid && bus4.out_ready) begin
            exp_t e;
            if (q4.size() == 0) begin
                checkOutput("sb4_unexpected", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                checkOutput("sb4_sum", {16'd0, bus4.sum}, {16'd0, e.sum});
                checkOutput("sb4_cout", {31'd0, bus4.cout}, {31'd0, e.cout});
            end
        end
    end

    // Monitor for the single-slice build.
    always @(negedge clk) begin
        if (!rst && bus1.out_valid && bus1.out_ready) begin
            exp_t e;
            if (q1.size() == 0) begin
                checkOutput("sb1_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                checkOutput("sb1_sum", {28'd0, bus1.sum}, {16'd0, e.sum});
                checkOutput("sb1_cout", {31'd0, bus1.cout}, {31'd0, e.cout});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        setInputs(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        setInputs(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        setOutReady(1'b0, 1'b0);
        setOutReady(1'b1, 1'b0);
        #12;
        checkOutput("rst_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, bus4.busy}, 32'd0);
        checkOutput("rst_sum", {16'd0, bus4.sum}, 32'd0);
        checkOutput("rst_cout", {31'd0, bus4.cout}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] basic adds");
        applyStimulus(1'b0, 16'h3A7F, 16'h0C81, 1'b0, 16'h4700, 1'b0, 0);
        applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
        applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 0);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 3);

        $display("[TB] reset mid-run");
        setInputs(1'b0, 1'b1, 16'h1234, 16'h4321, 1'b1);
        @(posedge clk); #1;
        setInputs(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("mid_busy", {31'd0, bus4.busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        checkOutput("abort_busy", {31'd0, bus4.busy}, 32'd0);
        checkOutput("abort_sum", {16'd0, bus4.sum}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("abort_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 16'h3A7F, 16'h0C81, 1'b0, 16'h4700, 1'b0, 0);

        $display("[TB] single slice");
        applyStimulus(1'b1, 16'h000D, 16'h000E, 1'b0, 16'h000B, 1'b1, 0);
        applyStimulus(1'b1, 16'h0007, 16'h0008, 1'b1, 16'h0000, 1'b1, 1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb4_drained", q4.size(), 32'd0);
        checkOutput("sb1_drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
